// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory target: valid/ready load/store requests, one-shot response, big-endian words.
// Optional DATA_MEM_RESP_HOLD_EN adds resp_ready and holds the response until it is taken.

module data_mem_responder #(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
`ifdef DATA_MEM_RESP_HOLD_EN
   input  logic        resp_ready,
`endif
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   // state | meaning
   // IDLE  | ready for a request
   // WAIT  | request latched, counting down LATENCY cycles
   // RESP  | memory committed, response presented
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [3:0] LP_CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   logic [1:0]        r_state;
   logic [3:0]        r_cnt;
   logic              r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rdata;
   logic              r_err;
   logic [7:0]        r_mem [0:(2**ADDR_W)-1];

   logic              w_accept;
   logic              w_commit;
   logic              w_c_write;
   logic [ADDR_W-1:0] w_c_addr;
   logic [31:0]       w_c_wdata;
   logic              w_misal;
   logic [ADDR_W-3:0] w_word;
   logic              w_unused_addr;

   assign w_unused_addr = ^req_addr[31:ADDR_W];

   assign w_accept  = (r_state == ST_IDLE) && req_valid;
   // With zero latency the commit uses the live request, otherwise the latched copy.
   assign w_commit  = !rst && ((w_accept && (LATENCY == 0)) ||
                               ((r_state == ST_WAIT) && (r_cnt == 4'd0)));
   assign w_c_write = (r_state == ST_IDLE) ? req_write : r_write;
   assign w_c_addr  = (r_state == ST_IDLE) ? req_addr[ADDR_W-1:0] : r_addr;
   assign w_c_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
   assign w_misal   = |w_c_addr[1:0];
   assign w_word    = w_c_addr[ADDR_W-1:2];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= 32'd0;
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_write <= req_write;
                  r_addr  <= req_addr[ADDR_W-1:0];
                  r_wdata <= req_wdata;
                  r_cnt   <= LP_CNT_INIT;
                  r_state <= (LATENCY == 0) ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESP: begin
`ifdef DATA_MEM_RESP_HOLD_EN
               if (resp_ready) begin
                  r_state <= ST_IDLE;
               end
`else
               r_state <= ST_IDLE;
`endif
            end
            default: r_state <= ST_IDLE;
         endcase

         if (w_commit) begin
            r_err <= w_misal;
            if (!w_c_write && !w_misal) begin
               r_rdata <= {r_mem[{w_word, 2'd0}], r_mem[{w_word, 2'd1}],
                           r_mem[{w_word, 2'd2}], r_mem[{w_word, 2'd3}]};
            end else begin
               r_rdata <= 32'd0;
            end
         end
      end
   end

   // Storage has no reset; contents survive rst.
   always_ff @(posedge clk) begin
      if (w_commit && w_c_write && !w_misal) begin
         r_mem[{w_word, 2'd0}] <= w_c_wdata[31:24];
         r_mem[{w_word, 2'd1}] <= w_c_wdata[23:16];
         r_mem[{w_word, 2'd2}] <= w_c_wdata[15:8];
         r_mem[{w_word, 2'd3}] <= w_c_wdata[7:0];
      end
   end

   assign req_ready  = (r_state == ST_IDLE);
   assign resp_valid = (r_state == ST_RESP);
   assign busy       = (r_state != ST_IDLE);
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder (LATENCY=2, ADDR_W=8); the driver queues
// expected responses and a negedge monitor checks them, including arrival time.

module tb_data_mem_responder;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_ready = 1'b1;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        busy;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      time         t;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   data_mem_responder #(.ADDR_W(8), .LATENCY(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
`ifdef DATA_MEM_RESP_HOLD_EN
      .resp_ready (resp_ready),
`endif
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every visible response is matched against the oldest expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (busy) chk("ready_low_while_busy", {63'd0, req_ready}, 64'd0);
         if (resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_resp", {63'd0, resp_valid}, 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("resp_rdata", {32'd0, resp_rdata}, {32'd0, e.rd});
               chk("resp_err", {63'd0, resp_err}, {63'd0, e.err});
               if (e.t != 0) chk("resp_time", $time, e.t);
            end
         end
      end
   end

   // Presents a request from a negedge and returns just after the accepting posedge.
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic ee, input bit push,
                        input bit timed, output time t_acc);
      int n;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("handshake_ready", {63'd0, req_ready}, 64'd1);
      t_acc = $time + 5;
      if (push) sb.push_back('{er, ee, timed ? (t_acc + LAT * 10 + 5) : 0});
      @(posedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      req_valid = 1'b0;
      while ((sb.size() != 0 || busy) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      time t0, t1, t2;

      // Reset with a request pending: reset must win.
      rst = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr = 32'h10;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
      chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("rst_resp_rdata", {32'd0, resp_rdata}, 64'd0);
      chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
      chk("rst_wait_cnt", {60'd0, dut.r_cnt}, 64'd0);
      req_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;

      issue(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 1'b1, t0);
      issue(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, t1);
      chk("b2b_accept_period", t1 - t0, 64'(LAT + 2) * 10);

      issue(1'b1, 32'h20, 32'h11223344, 32'h0, 1'b0, 1'b1, 1'b1, t0);
      issue(1'b0, 32'h20, 32'h0, 32'h11223344, 1'b0, 1'b1, 1'b1, t1);
      chk("byte_0x20", {56'd0, dut.r_mem[8'h20]}, 64'h11);
      chk("byte_0x21", {56'd0, dut.r_mem[8'h21]}, 64'h22);
      chk("byte_0x22", {56'd0, dut.r_mem[8'h22]}, 64'h33);
      chk("byte_0x23", {56'd0, dut.r_mem[8'h23]}, 64'h44);

      issue(1'b1, 32'h21, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1, 1'b1, t0);
      issue(1'b0, 32'h20, 32'h0, 32'h11223344, 1'b0, 1'b1, 1'b1, t0);
      issue(1'b0, 32'h22, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, t0);

      issue(1'b1, 32'h00000104, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, 1'b1, t0);
      issue(1'b0, 32'h04, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1, t0);

      // Continuous req_valid: three accepts, each LAT+2 cycles apart.
      issue(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, t0);
      issue(1'b0, 32'h20, 32'h0, 32'h11223344, 1'b0, 1'b1, 1'b1, t1);
      issue(1'b0, 32'h04, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1, t2);
      chk("stream_period_1", t1 - t0, 64'(LAT + 2) * 10);
      chk("stream_period_2", t2 - t1, 64'(LAT + 2) * 10);

      // Reset during the second WAIT cycle discards the store.
      issue(1'b1, 32'h30, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1, 1'b1, t0);
      drain();
      issue(1'b1, 32'h30, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0, t0);
      @(posedge clk);
      #1 rst = 1'b1;
      req_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("after_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("after_rst_req_ready", {63'd0, req_ready}, 64'd1);
      chk("after_rst_busy", {63'd0, busy}, 64'd0);
      issue(1'b0, 32'h30, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b1, t0);
      drain();

`ifdef DATA_MEM_RESP_HOLD_EN
      begin
         int n;
         resp_ready = 1'b0;
         issue(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, t0);
         req_valid = 1'b0;
         n = 0;
         @(negedge clk);
         while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
         for (int c = 0; c < 3; c++) begin
            chk("hold_valid", {63'd0, resp_valid}, 64'd1);
            chk("hold_rdata", {32'd0, resp_rdata}, 64'hDEADBEEF);
            if (c < 2) @(negedge clk);
         end
         @(posedge clk);
         #1 resp_ready = 1'b1;
         @(negedge clk);
         chk("hold_valid_last", {63'd0, resp_valid}, 64'd1);
         @(negedge clk);
         chk("hold_released", {63'd0, resp_valid}, 64'd0);
         drain();
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
